// File: rtl/output_buffer.sv
// Accumulator output store: random-access register file or show-ahead
// stream FIFO, with occupancy and sticky overflow status.
module output_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] index,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mode_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovf;

  logic switch_c;
  logic stream;
  logic pop;
  logic push_req;
  logic push;
  logic drop;
  logic idx_wr;

  assign switch_c = mode != mode_q;
  assign stream   = mode_q;

  assign count    = cnt;
  assign overflow = ovf;
  assign empty    = cnt == '0;
  assign full     = cnt == FULL_CNT;

  assign out_valid = stream & ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full push can ride on it.
  assign pop      = out_valid & out_ready & ~switch_c & ~clear;
  assign push_req = stream & wr_en & ~switch_c & ~clear;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign idx_wr   = ~stream & wr_en & ~switch_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
      mode_q  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      if (rd_en) rd_data <= mem[index];

      if (idx_wr) mem[index] <= wr_data;
      else if (push) mem[wr_ptr] <= wr_data;

      if (switch_c) begin
        mode_q <= mode;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push & ~pop)      cnt <= cnt + 1'b1;
        else if (pop & ~push) cnt <= cnt - 1'b1;
        if (drop) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
Parametrised successor to the CPU's 32x8 output register. It stores accumulator results in a DATA_W x DEPTH array with two modes. Indexed mode gives random-access write and a registered read. Stream mode turns the array into a FIFO drained by external logic over a valid/ready handshake. It sits between the accumulator/control unit and the external output logic, and adds occupancy and overflow status for the control FSM.

Parameters:
DATA_W, 8, width of each stored word
DEPTH, 32, number of entries (power of two, >= 2)
ADDR_W, 5, index width, equal to log2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = indexed, 1 = stream
clear  input  1  synchronous flush of FIFO state and overflow flag
wr_en  input  1  write/push strobe
wr_data  input  DATA_W  value from accumulator
index  input  ADDR_W  write address (indexed mode) and peek address (both modes)
rd_en  input  1  registered read of memory[index]
rd_data  output  DATA_W  registered read result
out_valid  output  1  stream word available
out_ready  input  1  consumer accepts out_data
out_data  output  DATA_W  head-of-FIFO word
count  output  ADDR_W+1  FIFO occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: a stream push was dropped

Behaviour:
- Reset: all memory entries = 0, wr_ptr = rd_ptr = 0, count = 0, rd_data = 0, overflow = 0, mode_q = 0. Outputs after reset: empty = 1, full = 0, out_valid = 0.
- Reset mid-operation discards all state, including the stream contents.
- mode_q is the registered copy of mode. When mode != mode_q, that cycle is a switch cycle:
  - mode_q <= mode; wr_ptr, rd_ptr and count are zeroed.
  - wr_en and pops are ignored; rd_en still operates.
  - The new mode is active from the next cycle.
- Read (both modes): if rd_en, rd_data <= memory[index] with 1-cycle latency. rd_data holds its value while rd_en = 0.
  - Read and write to the same entry in the same cycle returns the old value (read-before-write).
- Indexed mode (mode_q = 0):
  - wr_en writes memory[index] <= wr_data.
  - out_valid = 0. count, empty, full and pointers hold their flushed values.
- Stream mode (mode_q = 1):
  - index is ignored for writes.
  - push = wr_en; it writes memory[wr_ptr] and increments wr_ptr.
  - pop = out_valid & out_ready; it increments rd_ptr.
  - out_valid = !empty, combinational.
  - out_data = memory[rd_ptr], combinational show-ahead; it is 0 when empty.
  - Pointers wrap from DEPTH-1 to 0.
  - count changes by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
- Boundary cases:
  - Push while full with no pop: word dropped, memory and pointers unchanged, overflow <= 1.
  - Push while full with a pop in the same cycle: both are accepted, count stays DEPTH, overflow unchanged.
  - Empty: out_valid = 0, so out_ready has no effect. A push on empty makes out_valid = 1 on the next cycle; there is no same-cycle fall-through.
  - out_data must stay stable while out_valid = 1 and out_ready = 0.
- clear: zeroes wr_ptr, rd_ptr, count and overflow. It has priority over push and pop in that cycle. Memory contents and rd_data are untouched.
- Priority, highest first: reset > switch cycle > clear > normal operation.
- overflow is cleared only by reset or clear.

Test Plan:
- Reset, then rd_en with index=7 -> rd_data=0x00 next cycle; empty=1, out_valid=0, overflow=0.
- Indexed: write 0xA5 to index 3, then rd_en index 3 -> rd_data=0xA5 one cycle later. Simultaneous write 0x5A to 3 with rd_en on 3 -> rd_data=0xA5, and the following read gives 0x5A.
- Stream: switch to mode=1, push 0x01,0x02,0x03 with out_ready=0 -> count=3, out_data=0x01. Raise out_ready -> out_data sequence 0x01,0x02,0x03, then empty=1.
- Stream full: push 32 words (0x00..0x1F) -> full=1. Push 0xFF with out_ready=0 -> dropped, overflow=1, count=32. Push 0xEE with a pop in the same cycle -> count=32, 0xEE emerges after 0x1F.
- Wrap: 40 pushes interleaved with pops, pointers crossing 31->0 -> output order equals input order, count never exceeds 32.
- clear with count=5 and overflow=1 -> next cycle count=0, empty=1, overflow=0. Toggling mode with data queued -> count=0, and wr_en in the switch cycle is ignored.
